spike_fifo_scheduler: RTL and testbench
=======================================

Name: spike_fifo_scheduler

Overview:
Sequencer for the bank of per-row 1-bit spike FIFOs that feed the systolic spike array. It runs in two phases.
- Load: accepts a burst of ROWS-wide spike vectors from the upstream buffer and pushes bit r of each vector into FIFO r.
- Stream: pops the FIFOs with a diagonal skew (row r starts r cycles after row 0), producing the staggered wavefront the array expects.
It owns all FIFO push, pop and clear strobes and tracks occupancy itself; the FIFOs carry no control logic.

Parameters:
- ROWS, 8, number of array rows (one 1-bit FIFO per row).
- DEPTH, 16, capacity of each FIFO in spikes (timesteps per burst).
- CW, $clog2(DEPTH+1), width of the num_steps and load counter (derived).
- SW, $clog2(DEPTH+ROWS), width of the stream counter (derived).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a burst; sampled only in IDLE.
- num_steps  in  CW  timesteps in the burst; latched on the accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the burst has fully streamed.
- in_valid  in  1  upstream spike vector is valid.
- in_ready  out  1  scheduler accepts a vector this cycle.
- in_spikes  in  ROWS  spike vector; bit r goes to row r.
- fifo_clr  out  1  synchronous clear to all FIFOs.
- fifo_wr_en  out  ROWS  push strobe per FIFO.
- fifo_wr_bit  out  ROWS  push data per FIFO.
- fifo_rd_en  out  ROWS  pop strobe per FIFO.
- fifo_rd_bit  in  ROWS  FIFO head bit; the FIFOs are first-word-fall-through.
- array_stall  in  1  array back-pressure; freezes streaming.
- arr_valid  out  ROWS  registered; row r spike is valid.
- arr_spike  out  ROWS  registered spike into array row r.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state returns to IDLE and all counters clear.
  - Every output is 0 the following cycle: busy, done, in_ready, fifo_clr, fifo_wr_en, fifo_rd_en, arr_valid, arr_spike.
  - A reset mid-burst abandons it: no done pulse. FIFO contents are stale but are cleared by the next start.
- FSM states: IDLE, LOAD, STREAM, DONE.
- IDLE:
  - start=1: latch n = min(num_steps, DEPTH). Values above DEPTH clamp to DEPTH.
  - Assert fifo_clr for exactly that one cycle.
  - Next state is LOAD if n>0, otherwise DONE (no push or pop is ever issued).
- LOAD:
  - in_ready = (load_cnt < n), combinational from state.
  - Each handshake (in_valid & in_ready): fifo_wr_en = all ones, fifo_wr_bit = in_spikes, load_cnt increments. Bit r is written to FIFO r in the same cycle.
  - When the handshake brings load_cnt to n, go to STREAM. in_ready is 0 from that next cycle on.
  - in_valid=0 simply waits; there is no timeout.
- STREAM:
  - Stream counter s starts at 0.
  - Row r pops (fifo_rd_en[r]=1) when !array_stall and r <= s < r+n.
  - s increments only when !array_stall.
  - On the non-stalled cycle with s == n+ROWS-2, go to DONE.
  - Total non-stalled stream cycles: n+ROWS-1.
- DONE: done=1 for one cycle, busy still 1; next state IDLE.
- Array outputs, registered with 1-cycle latency from the pop:
  - arr_valid[r] <= fifo_rd_en[r].
  - arr_spike[r] <= fifo_rd_en[r] & fifo_rd_bit[r].
  - During a stall both are 0 for every row. The wavefront resumes with no bit lost or repeated.
- Start while busy is ignored: no latch, no fifo_clr.
- Invariants, to be asserted by the bench:
  - Row r pops exactly n times per burst and never pops an empty FIFO.
  - The FIFOs are never pushed when full, because n <= DEPTH.
  - fifo_wr_en and fifo_rd_en are never both active in the same cycle (the phases are disjoint).

Decomposition:
- Shared package spiketpu_pkg holds:
  - the state enum type sched_state_t (IDLE, LOAD, STREAM, DONE);
  - the default ROWS and DEPTH constants shared with the array and the FIFO bank.
- One natural sub-module: skew_window, a combinational per-row compare of r <= s < r+n that yields the ROWS-bit pop mask.
- Everything else stays flat in spike_fifo_scheduler.

Test Plan (ROWS=4, DEPTH=8, behavioural FWFT 1-bit FIFO model):
1. Hold rst 3 cycles, then release -> all outputs 0, busy=0, in_ready=0; start with rst=1 is ignored.
2. start with num_steps=3; push vectors 4'b1010, 4'b0110, 4'b1111 with no stall:
   - fifo_clr pulses once.
   - arr row0 valid on stream cycles 1..3 (registered) with bits 0,0,1.
   - arr row3 valid on cycles 4..6 with bits 1,0,1.
   - done pulses exactly once, 1 cycle after the 6th stream cycle.
3. Same burst, but array_stall=1 for 2 cycles at s=2 -> arr_valid=0 on the 2 cycles after the stall. Per-row bit sequences are identical to scenario 2; done is delayed by exactly 2 cycles.
4. num_steps=0 -> fifo_clr, then done the next cycle; no push or pop; in_ready never 1.
5. num_steps=12 -> clamped: exactly 8 handshakes accepted, in_ready drops after the 8th, each row pops 8 times; start during LOAD is ignored.
6. Reset asserted in STREAM at s=3 -> next cycle all outputs 0 and no done. A fresh start with num_steps=1 and vector 4'b0001 completes: row0 arr_spike=1, rows 1..3 arr_spike=0.

Source files
------------

// File: rtl/spiketpu_pkg.sv
// Shared types and default geometry for the spike TPU front end
// (scheduler, FIFO bank, systolic array).
package spiketpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } sched_state_t;

    localparam int unsigned ROWS_DEF  = 8;
    localparam int unsigned DEPTH_DEF = 16;

endpackage

// File: rtl/spike_fifo_scheduler_if.sv
// Upstream handshake, per-row FIFO bank strobes and array-side spike bus.
// The master modport is the scheduler side; slave is the surrounding fabric.
interface spike_fifo_scheduler_if
    import spiketpu_pkg::*;
#(
    parameter int unsigned ROWS = ROWS_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [ROWS-1:0] in_spikes;
    logic            fifo_clr;
    logic [ROWS-1:0] fifo_wr_en;
    logic [ROWS-1:0] fifo_wr_bit;
    logic [ROWS-1:0] fifo_rd_en;
    logic [ROWS-1:0] fifo_rd_bit;
    logic            array_stall;
    logic [ROWS-1:0] arr_valid;
    logic [ROWS-1:0] arr_spike;

    modport master (
        input  in_valid, in_spikes, fifo_rd_bit, array_stall,
        output in_ready, fifo_clr, fifo_wr_en, fifo_wr_bit, fifo_rd_en,
               arr_valid, arr_spike
    );

    modport slave (
        output in_valid, in_spikes, fifo_rd_bit, array_stall,
        input  in_ready, fifo_clr, fifo_wr_en, fifo_wr_bit, fifo_rd_en,
               arr_valid, arr_spike
    );
endinterface

// File: rtl/skew_window.sv
// Diagonal pop mask: row r is inside the wavefront while r <= s < r+n.
module skew_window #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned CW   = 5,
    parameter int unsigned SW   = 5
) (
    input  logic [SW-1:0]   s,
    input  logic [CW-1:0]   n,
    output logic [ROWS-1:0] mask
);
    always_comb begin
        mask = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            mask[r] = (32'(s) >= r) && (32'(s) < r + 32'(n));
        end
    end
endmodule

// File: rtl/spike_fifo_scheduler.sv
// Two-phase sequencer for the per-row spike FIFOs: loads a burst of spike
// vectors, then streams them out as a diagonally skewed wavefront.
module spike_fifo_scheduler
    import spiketpu_pkg::*;
#(
    parameter int unsigned ROWS  = ROWS_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CW    = $clog2(DEPTH + 1),
    parameter int unsigned SW    = $clog2(DEPTH + ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CW-1:0]          num_steps,
    output logic                   busy,
    output logic                   done,
    spike_fifo_scheduler_if.master bus
);
    localparam int unsigned SW1 = SW + 1;

    sched_state_t    state_q, state_d;
    logic [CW-1:0]   n_q, load_cnt_q, n_clamped;
    logic [SW-1:0]   s_q;
    logic [SW:0]     last_s;
    logic [ROWS-1:0] pop_mask;
    logic            accept, load_open, hs, stream_go, stream_last;

    assign n_clamped   = (32'(num_steps) > DEPTH) ? CW'(DEPTH) : num_steps;
    assign accept      = (state_q == IDLE) && start;
    assign load_open   = (state_q == LOAD) && (load_cnt_q < n_q);
    assign hs          = bus.in_valid && load_open;
    assign stream_go   = (state_q == STREAM) && !bus.array_stall;
    // Last stream step is s == n+ROWS-2; one extra bit keeps the sum exact.
    assign last_s      = SW1'(n_q) + SW1'(ROWS) - SW1'(2);
    assign stream_last = stream_go && ({1'b0, s_q} == last_s);

    skew_window #(
        .ROWS (ROWS),
        .CW   (CW),
        .SW   (SW)
    ) u_skew (
        .s    (s_q),
        .n    (n_q),
        .mask (pop_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (n_clamped != '0) ? LOAD : DONE;
            LOAD:    if (hs && (load_cnt_q + CW'(1) == n_q)) state_d = STREAM;
            STREAM:  if (stream_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q        <= '0;
            load_cnt_q <= '0;
            s_q        <= '0;
        end else begin
            if (accept) begin
                n_q        <= n_clamped;
                load_cnt_q <= '0;
                s_q        <= '0;
            end
            if (hs)        load_cnt_q <= load_cnt_q + CW'(1);
            if (stream_go) s_q        <= s_q + SW'(1);
        end
    end

    always_comb begin
        busy            = (state_q != IDLE);
        done            = (state_q == DONE);
        bus.in_ready    = load_open;
        bus.fifo_clr    = accept && !rst;
        bus.fifo_wr_en  = '0;
        bus.fifo_wr_bit = '0;
        bus.fifo_rd_en  = '0;
        if (hs) begin
            bus.fifo_wr_en  = '1;
            bus.fifo_wr_bit = bus.in_spikes;
        end
        if (stream_go) bus.fifo_rd_en = pop_mask;
    end

    // A stalled cycle issues no pop, so both array outputs fall to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.arr_valid <= '0;
            bus.arr_spike <= '0;
        end else begin
            bus.arr_valid <= bus.fifo_rd_en;
            bus.arr_spike <= bus.fifo_rd_en & bus.fifo_rd_bit;
        end
    end
endmodule

// File: tb/tb_spike_fifo_scheduler.sv
// Bench for spike_fifo_scheduler with a behavioural FWFT 1-bit FIFO bank
// and a per-row scoreboard of loaded spike vectors.
module tb_spike_fifo_scheduler;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_steps;
    logic          busy;
    logic          done;

    spike_fifo_scheduler_if #(.ROWS(ROWS)) bus ();

    spike_fifo_scheduler #(
        .ROWS  (ROWS),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_steps (num_steps),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {8'h00, busy, done, bus.in_ready, bus.fifo_clr, bus.fifo_wr_en,
                bus.fifo_wr_bit, bus.fifo_rd_en, bus.arr_valid, bus.arr_spike};
    endfunction

    // Behavioural FIFO bank: circular buffers with head bit fall-through.
    logic            fmem [ROWS][DEPTH];
    int              fcnt [ROWS];
    int              frp  [ROWS];
    int              fwp  [ROWS];
    logic [ROWS-1:0] head;

    always_comb begin
        head = '0;
        for (int r = 0; r < ROWS; r++) if (fcnt[r] > 0) head[r] = fmem[r][frp[r]];
    end
    assign bus.fifo_rd_bit = head;

    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (bus.fifo_clr) begin
                fcnt[r] <= 0;
                frp[r]  <= 0;
                fwp[r]  <= 0;
            end else begin
                if (bus.fifo_wr_en[r]) begin
                    fmem[r][fwp[r]] <= bus.fifo_wr_bit[r];
                    fwp[r] <= (fwp[r] + 1) % int'(DEPTH);
                end
                if (bus.fifo_rd_en[r]) frp[r] <= (frp[r] + 1) % int'(DEPTH);
                fcnt[r] <= fcnt[r] + (bus.fifo_wr_en[r] ? 1 : 0) - (bus.fifo_rd_en[r] ? 1 : 0);
            end
        end
    end

    // Scoreboard and per-burst statistics, sampled on the falling edge.
    logic [ROWS-1:0] sb_q[$];
    int  sb_idx  [ROWS];
    int  pops    [ROWS];
    int  first_v [ROWS];
    int  last_v  [ROWS];
    int  cyc = 0, hs_cnt = 0, clr_total = 0, done_total = 0, done_burst = 0, done_cyc = -1;
    bit  seen_ready = 0, stall_prev = 0;
    logic [ROWS-1:0] stim_q[$];

    initial forever begin
        logic [ROWS-1:0] v;
        bit              all_used;
        @(negedge clk);
        if (bus.fifo_clr === 1'b1) begin
            cyc = 0; clr_total++; hs_cnt = 0; done_burst = 0; done_cyc = -1; seen_ready = 0;
            sb_q.delete();
            for (int r = 0; r < ROWS; r++) begin
                sb_idx[r] = 0; pops[r] = 0; first_v[r] = -1; last_v[r] = -1;
            end
        end else begin
            cyc++;
        end
        if (bus.in_ready === 1'b1) seen_ready = 1;
        if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(bus.in_spikes);
            hs_cnt++;
        end
        if ((|bus.fifo_wr_en) || (|bus.fifo_rd_en))
            check("wr_rd_disjoint", 32'((|bus.fifo_wr_en) && (|bus.fifo_rd_en)), 0);
        check("spike_gated", 32'(bus.arr_spike & ~bus.arr_valid), 0);
        if (stall_prev) check("stall_gap", 32'(bus.arr_valid), 0);
        stall_prev = bus.array_stall;
        for (int r = 0; r < ROWS; r++) begin
            if (bus.fifo_rd_en[r]) begin
                check($sformatf("pop_nonempty_r%0d", r), 32'(fcnt[r] > 0), 1);
                pops[r]++;
            end
            if (bus.fifo_wr_en[r]) check($sformatf("push_notfull_r%0d", r), 32'(fcnt[r] < DEPTH), 1);
            if (bus.arr_valid[r] === 1'b1) begin
                if (first_v[r] < 0) first_v[r] = cyc;
                last_v[r] = cyc;
                check($sformatf("sb_avail_r%0d", r), 32'(sb_idx[r] < sb_q.size()), 1);
                if (sb_idx[r] < sb_q.size()) begin
                    v = sb_q[sb_idx[r]];
                    check($sformatf("arr_spike_r%0d", r), 32'(bus.arr_spike[r]), 32'(v[r]));
                    sb_idx[r]++;
                end
            end
        end
        all_used = (sb_q.size() > 0);
        for (int r = 0; r < ROWS; r++) if (sb_idx[r] == 0) all_used = 0;
        if (all_used) begin
            void'(sb_q.pop_front());
            for (int r = 0; r < ROWS; r++) sb_idx[r]--;
        end
        if (done === 1'b1) begin
            done_total++; done_burst++; done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input int n_req, input int stall_at, input int stall_len, input bit start_mid);
        int exp_n, base_clr, base_done, budget;
        exp_n     = (n_req > int'(DEPTH)) ? int'(DEPTH) : n_req;
        base_clr  = clr_total;
        base_done = done_total;
        start = 1; num_steps = CW'(n_req);
        tick();
        start = 0;
        for (int i = 0; i < stim_q.size(); i++) begin
            bus.in_valid = 1; bus.in_spikes = stim_q[i];
            budget = 0;
            while (!bus.in_ready && budget < 4) begin tick(); budget++; end
            if (!bus.in_ready) break;
            if (start_mid && i == 2) begin start = 1; num_steps = CW'(2); end
            tick();
            start = 0;
        end
        bus.in_valid = 0; bus.in_spikes = '0;
        if (stall_len > 0) begin
            budget = 0;
            while (!bus.fifo_rd_en[0] && budget < 50) begin tick(); budget++; end
            check("stream_start_seen", 32'(bus.fifo_rd_en[0]), 1);
            repeat (stall_at) tick();
            bus.array_stall = 1;
            repeat (stall_len) tick();
            bus.array_stall = 0;
        end
        budget = 0;
        while (done_total == base_done && budget < 200) begin tick(); budget++; end
        repeat (3) tick();
        check("done_once", done_burst, 1);
        check("clr_once", clr_total - base_clr, 1);
        check("handshakes", hs_cnt, exp_n);
        check("ready_seen", 32'(seen_ready), 32'(exp_n > 0));
        for (int r = 0; r < ROWS; r++) check($sformatf("pops_r%0d", r), pops[r], exp_n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n, stall, base_done;
        rst = 1; start = 1; num_steps = CW'(3);
        bus.in_valid = 0; bus.in_spikes = '0; bus.array_stall = 0;

        // Reset held 3 cycles with start high; start must not leak through.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs(), 0);
        @(posedge clk); #1;
        rst = 0; start = 0;
        @(negedge clk);
        check("idle_outputs", outs(), 0);
        check("clr_during_reset", clr_total, 0);
        tick();

        // Nominal burst, then the same burst with a 2-cycle stall at s=2.
        for (int k = 0; k < 2; k++) begin
            n = 3; stall = (k == 1) ? 2 : 0;
            stim_q = '{4'b1010, 4'b0110, 4'b1111};
            run_burst(n, 2, stall, 0);
            check("row0_first", first_v[0], n + 2);
            check("row3_first", first_v[3], n + 2 + int'(ROWS) - 1 + stall);
            check("row3_last", last_v[3], 2 * n + int'(ROWS) + stall);
            check("done_cycle", done_cyc, 2 * n + int'(ROWS) + stall);
        end

        // Empty burst goes straight to DONE.
        stim_q.delete();
        run_burst(0, 0, 0, 0);
        check("zero_done_cycle", done_cyc, 1);

        // Oversized burst clamps to DEPTH; a start during LOAD is ignored.
        stim_q.delete();
        for (int i = 0; i < 12; i++) stim_q.push_back(ROWS'($urandom));
        run_burst(12, 0, 0, 1);

        // Reset in STREAM at s=3 abandons the burst without a done pulse.
        base_done = done_total;
        start = 1; num_steps = CW'(3);
        tick();
        start = 0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1; bus.in_spikes = ROWS'($urandom);
            tick();
        end
        bus.in_valid = 0; bus.in_spikes = '0;
        repeat (3) tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        check("post_reset_outputs", outs(), 0);
        repeat (10) tick();
        check("no_done_after_reset", done_total - base_done, 0);

        stim_q = '{4'b0001};
        run_burst(1, 0, 0, 0);
        check("fresh_row0_first", first_v[0], 3);
        check("fresh_done_cycle", done_cyc, 2 + int'(ROWS));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
